rx_sample_fifo: RTL and testbench

//  Elastic sample buffer between the receive deserializer (8-bit parallel word + valid) and the
//  20 kHz DAC resampling / save-memory path. Absorbs the jitter between the deserializer's

---
 rtl/rx_sample_fifo.sv | 112 +++++++++++
 tb/tb_rx_sample_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_sample_fifo.sv
// rtl/rx_sample_fifo.sv - elastic sample buffer between the receive deserializer and the playback path
// Prefills to PREFILL entries before playing; an empty read at a tick outputs silence and refills.
module rx_sample_fifo #(
  parameter int WIDTH   = 8,
  parameter int AW      = 4,
  parameter int PREFILL = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_tick,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             playing,
  output logic [AW:0]      level,
  output logic [15:0]      underflow_cnt,
  output logic [15:0]      overflow_cnt
);

  localparam int          DEPTH     = 2 ** AW;
  localparam logic [AW:0] DEPTH_L   = (AW + 1)'(DEPTH);
  localparam logic [AW:0] PREFILL_L = (AW + 1)'(PREFILL);

  typedef enum logic {FILL, PLAY} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_cnt_q, wr_cnt_d;
  logic [AW:0]      rd_cnt_q, rd_cnt_d;
  logic             wr_valid_q, wr_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [15:0]      unf_q, unf_d;
  logic [15:0]      ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic        we, pop, push, empty, full;
  logic [AW:0] level_w;

  // Free-running counters one bit wider than the address make full/empty unambiguous.
  assign level_w = wr_cnt_q - rd_cnt_q;
  assign empty   = (level_w == '0);
  assign full    = (level_w == DEPTH_L);

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wr_valid_d = wr_valid;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    unf_d      = unf_q;
    ovf_d      = ovf_q;

    we   = wr_valid && !wr_valid_q;
    pop  = (state_q == PLAY) && rd_tick && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the write.
    push = we && (!full || pop);

    if (push) wr_cnt_d = wr_cnt_q + 1'b1;
    if (pop)  rd_cnt_d = rd_cnt_q + 1'b1;
    if (we && full && !pop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;

    if (rd_tick) rd_data_d = pop ? mem_q[rd_cnt_q[AW-1:0]] : '0;
    rd_valid_d = pop;

    case (state_q)
      FILL: if (level_w >= PREFILL_L) state_d = PLAY;
      PLAY: begin
        if (rd_tick && empty) begin
          state_d = FILL;
          if (unf_q != 16'hFFFF) unf_d = unf_q + 16'd1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FILL;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      unf_q      <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_valid_q <= wr_valid_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      unf_q      <= unf_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_cnt_q[AW-1:0]] <= wr_data;
  end

  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign playing       = (state_q == PLAY);
  assign level         = level_w;
  assign underflow_cnt = unf_q;
  assign overflow_cnt  = ovf_q;

endmodule

// File: tb/tb_rx_sample_fifo.sv
// tb/tb_rx_sample_fifo.sv - scoreboard bench for rx_sample_fifo against a queue-based reference model
module tb_rx_sample_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_tick = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       playing;
  logic [4:0] level;
  logic [15:0] underflow_cnt;
  logic [15:0] overflow_cnt;

  rx_sample_fifo dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .rd_tick(rd_tick),
    .rd_data(rd_data), .rd_valid(rd_valid), .playing(playing), .level(level),
    .underflow_cnt(underflow_cnt), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: the buffered samples as a plain queue plus a play flag.
  logic [7:0] m_q[$];
  bit         m_play;
  bit         m_wv_prev;
  int         m_unf;
  int         m_ovf;
  logic [8:0] exp_q[$];
  bit         tick_prev = 1'b0;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_clear();
    m_q.delete();
    exp_q.delete();
    m_play = 0;
    m_wv_prev = 0;
    m_unf = 0;
    m_ovf = 0;
  endfunction

  function automatic void model_edge(input bit wv, input logic [7:0] wd, input bit tk);
    int  lvl0 = m_q.size();
    bit  we = wv && !m_wv_prev;
    bit  popped = 0;
    bit  next_play;
    m_wv_prev = wv;
    next_play = m_play ? 1'b1 : (lvl0 >= 8);
    if (tk) begin
      if (m_play && lvl0 > 0) begin
        exp_q.push_back({1'b1, m_q.pop_front()});
        popped = 1;
      end else begin
        exp_q.push_back(9'h000);
        if (m_play) begin
          if (m_unf < 65535) m_unf++;
          next_play = 0;
        end
      end
    end
    if (we) begin
      if (lvl0 == 16 && !popped) begin
        if (m_ovf < 65535) m_ovf++;
      end else begin
        m_q.push_back(wd);
      end
    end
    m_play = next_play;
  endfunction

  task automatic step(input bit wv, input logic [7:0] wd, input bit tk);
    wr_valid = wv;
    wr_data  = wd;
    rd_tick  = tk;
    model_edge(wv, wd, tk);
    @(posedge clk);
    #1;
    check("level", int'(level), m_q.size());
    check("playing", int'(playing), int'(m_play));
    check("underflow_cnt", int'(underflow_cnt), m_unf);
    check("overflow_cnt", int'(overflow_cnt), m_ovf);
  endtask

  task automatic write1(input logic [7:0] v);
    step(1'b1, v, 1'b0);
    step(1'b0, v, 1'b0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    wr_valid = 1'b0;
    rd_tick  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    check("rst_level", int'(level), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_unf", int'(underflow_cnt), 0);
    check("rst_ovf", int'(overflow_cnt), 0);
  endtask

  // Monitor: every tick owes one response on the following cycle, and every rd_valid must be owed.
  always @(posedge clk) tick_prev = rd_tick && !reset;

  always @(negedge clk) begin
    if (!reset && (tick_prev || rd_valid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", int'({rd_valid, rd_data}), -1);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("rd_valid", int'(rd_valid), int'(e[8]));
        check("rd_data", int'(rd_data), int'(e[7:0]));
      end
    end
  end

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1: prefill with 1..8, then drain with 8 ticks
    for (int i = 1; i <= 8; i++) write1(8'(i));
    check("t1_playing", int'(playing), 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
    end

    // 2: held wr_valid writes once
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("t2_level", int'(level), 1);

    // 3: 17 writes, the last is dropped
    do_reset();
    for (int i = 0; i < 17; i++) write1(8'(8'h20 + i));
    check("t3_level", int'(level), 16);
    check("t3_ovf", int'(overflow_cnt), 1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // 4: play down to one sample, then two ticks -> sample then underflow
    do_reset();
    for (int i = 0; i < 8; i++) write1(8'(8'h40 + i));
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check("t4_unf", int'(underflow_cnt), 1);
    check("t4_playing", int'(playing), 0);
    check("t4_rd_data", int'(rd_data), 0);

    // 5: full in PLAY, write and tick together
    do_reset();
    for (int i = 0; i < 16; i++) write1(8'(8'h60 + i));
    step(1'b1, 8'hA5, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check("t5_level", int'(level), 16);
    check("t5_ovf", int'(overflow_cnt), 0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    check("t5_last", int'(rd_data), 8'hA5);
    step(1'b0, 8'h00, 1'b0);

    // 6: reset while playing with 10 samples buffered
    do_reset();
    for (int i = 0; i < 10; i++) write1(8'(8'h80 + i));
    check("t6_pre_level", int'(level), 10);
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Random traffic with occasional mid-run resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 3) == 0));
      end
    end
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("exp_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
